// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern engine: walk/bounce/count/blink with a programmable step rate
// A debounced push-button cycles through the modes.
module led_pattern_gen #(
  parameter int LED_WIDTH       = 8,
  parameter int CLK_HZ          = 50000000,
  parameter int STEP_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 CLOCK_50,
  input  logic                 KEY,
  input  logic                 KEY_MODE,
  input  logic [1:0]           SPEED,
  output logic [LED_WIDTH-1:0] LED,
  output logic [1:0]           MODE,
  output logic                 TICK
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int PW       = $clog2(TICK_DIV + 1);
  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [LED_WIDTH-1:0] LED_LSB = LED_WIDTH'(1);
  localparam logic [LED_WIDTH-1:0] LED_MSB = {1'b1, {(LED_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  mode_e                mode_q, mode_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 dir_q, dir_d;
  logic                 tick_q, tick_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [PW-1:0]        presc_term;
  logic                 wrap;

  logic                 sync1_q, sync2_q;
  logic                 level_q, level_d;
  logic [DW-1:0]        db_cnt_q, db_cnt_d;
  logic                 db_done;
  logic                 press;

  // Button path: 2-flop synchroniser, then a level must stay stable for DEBOUNCE_CYCLES.
  assign db_done = (sync2_q != level_q) && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
  assign press   = db_done && level_q;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q + DW'(1);
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_done) begin
      db_cnt_d = '0;
      level_d  = sync2_q;
    end
  end

  // A compare-with->= lets a SPEED change that strands the count above the new terminal wrap at once.
  assign presc_term = PW'((TICK_DIV >> SPEED) - 1);
  assign wrap       = (presc_q >= presc_term);

  always_comb begin
    presc_d = presc_q + PW'(1);
    tick_d  = wrap;
    if (wrap || press) begin
      presc_d = '0;
    end
  end

  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    dir_d  = dir_q;
    if (press) begin
      mode_d = mode_e'(mode_q + 2'd1);
      dir_d  = 1'b0;
      case (mode_d)
        MODE_WALK:   led_d = LED_LSB;
        MODE_BOUNCE: led_d = LED_LSB;
        MODE_COUNT:  led_d = '0;
        MODE_BLINK:  led_d = '1;
        default:     led_d = LED_LSB;
      endcase
    end else if (wrap) begin
      case (mode_q)
        MODE_WALK: begin
          led_d = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
        end
        MODE_BOUNCE: begin
          if (!dir_q) begin
            led_d = {led_q[LED_WIDTH-2:0], 1'b0};
            if (led_d == LED_MSB) begin
              dir_d = 1'b1;
            end
          end else begin
            led_d = {1'b0, led_q[LED_WIDTH-1:1]};
            if (led_d == LED_LSB) begin
              dir_d = 1'b0;
            end
          end
        end
        MODE_COUNT: begin
          led_d = led_q + LED_WIDTH'(1);
        end
        MODE_BLINK: begin
          led_d = ~led_q;
        end
        default: begin
          led_d = led_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      mode_q   <= MODE_WALK;
      led_q    <= LED_LSB;
      dir_q    <= 1'b0;
      tick_q   <= 1'b0;
      presc_q  <= '0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      level_q  <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      mode_q   <= mode_d;
      led_q    <= led_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
      presc_q  <= presc_d;
      sync1_q  <= KEY_MODE;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign LED  = led_q;
  assign MODE = mode_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen
// Stimulus pushes expected per-tick patterns; a negedge monitor pops and compares.
module tb_led_pattern_gen;

  localparam int W       = 8;
  localparam int CLK_HZ  = 16;
  localparam int STEP_HZ = 1;
  localparam int DEB     = 4;
  localparam int DIV     = CLK_HZ / STEP_HZ;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_mode = 1'b1;
  logic [1:0]   speed = 2'd0;
  logic [W-1:0] led;
  logic [1:0]   mode;
  logic         tick;

  led_pattern_gen #(
    .LED_WIDTH(W), .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLOCK_50(clk), .KEY(rst_n), .KEY_MODE(key_mode), .SPEED(speed),
    .LED(led), .MODE(mode), .TICK(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] led;
    logic [1:0]   mode;
    int           gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   idle = 1'b1;
  int   cyc = 0;
  int   since_tick = 0;
  int   n_changes = 0;
  int   last_change_cyc = 0;
  int   coincide = 0;
  logic [1:0] prev_mode = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Pattern after k steps in mode m, counted from the mode's entry pattern.
  function automatic logic [W-1:0] model_led(input int m, input int k);
    int p;
    int pos;
    case (m)
      0: return W'(1) << (k % W);
      1: begin
        p   = k % (2 * (W - 1));
        pos = (p < W) ? p : 2 * (W - 1) - p;
        return W'(1) << pos;
      end
      2: return W'(k % (1 << W));
      default: return (k % 2 == 1) ? '0 : '1;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    since_tick++;
    if (!rst_n) begin
      prev_mode  = 2'd0;
      since_tick = 0;
    end else begin
      if (mode !== prev_mode) begin
        n_changes++;
        last_change_cyc = cyc;
        check("mode_advance", mode, (prev_mode + 1) % 4);
        check("init_pattern", led, model_led(mode, 0));
        if (tick === 1'b1) coincide++;
        prev_mode = mode;
      end
      if (tick === 1'b1) begin
        if (!idle) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_tick: got tick with led %0h, expected no tick (cycle %0d)", led, cyc);
          end else begin
            e = sb_q.pop_front();
            check("tick_led", led, e.led);
            check("tick_mode", mode, e.mode);
            if (e.gap != 0) check("tick_gap", since_tick, e.gap);
          end
        end
        since_tick = 0;
      end
    end
  end

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() > 0; i++) step_cycles(1);
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic push_mode(input int m, input int first_k, input int n, input int spd, input bit first_gap);
    exp_t e;
    for (int k = first_k; k < first_k + n; k++) begin
      e.led  = model_led(m, k);
      e.mode = 2'(m);
      e.gap  = (k == first_k && !first_gap) ? 0 : (DIV >> spd);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_press(output int lat);
    int fall;
    int start;
    start = n_changes;
    idle = 1'b1;
    step_cycles(1);
    key_mode = 1'b0;
    fall = cyc;
    for (int i = 0; i < 30 && n_changes == start; i++) step_cycles(1);
    if (n_changes == start) begin
      n_checks++;
      $display("FAIL press_timeout: no mode change, expected one within 30 cycles");
      lat = -1;
    end else begin
      lat = last_change_cyc - fall;
    end
  endtask

  task automatic run_mode(input int m, input int nticks, input int spd);
    int lat;
    speed = 2'(spd);
    do_press(lat);
    check("press_latency", (lat >= DEB + 1 && lat <= DEB + 4), 1);
    push_mode(m, 1, nticks, spd, 1'b0);
    idle = 1'b0;
    key_mode = 1'b1;
    step_cycles(12);
    wait_drain(nticks * (DIV >> spd) + 40);
  endtask

  initial begin
    int start;
    int fall;
    int spd;

    step_cycles(3);
    check("reset_led", led, 1);
    check("reset_mode", mode, 0);
    check("reset_tick", tick, 0);
    rst_n = 1'b1;
    push_mode(0, 1, 9, 0, 1'b0);
    idle = 1'b0;
    wait_drain(9 * DIV + 40);

    run_mode(1, 16, $urandom_range(0, 3));
    run_mode(2, 256, 3);
    // Prescaler count is 1 here; dropping to SPEED 0 stretches the next step.
    speed = 2'd0;
    push_mode(2, 257, 1, 0, 1'b1);
    wait_drain(40);
    run_mode(3, $urandom_range(4, 10), $urandom_range(0, 3));
    run_mode(0, $urandom_range(3, 8), $urandom_range(0, 3));

    idle  = 1'b1;
    start = n_changes;
    repeat (8) begin
      key_mode = 1'b0;
      step_cycles($urandom_range(1, DEB - 1));
      key_mode = 1'b1;
      step_cycles($urandom_range(1, 6));
    end
    step_cycles(10);
    check("glitch_no_change", n_changes - start, 0);
    check("glitch_mode", mode, 0);

    start = n_changes;
    key_mode = 1'b0;
    fall = cyc;
    step_cycles(40);
    check("held_one_advance", n_changes - start, 1);
    check("held_latency", (last_change_cyc - fall >= DEB + 1 && last_change_cyc - fall <= DEB + 4), 1);
    key_mode = 1'b1;
    step_cycles(12);
    check("release_no_advance", n_changes - start, 1);
    check("held_mode", mode, 1);

    speed = 2'd0;
    for (int o = 0; o < DIV; o++) begin
      for (int i = 0; i < 40 && tick !== 1'b1; i++) step_cycles(1);
      step_cycles(o);
      key_mode = 1'b0;
      step_cycles(10);
      key_mode = 1'b1;
      step_cycles(10);
    end
    check("coincident_press_seen", coincide >= 1, 1);

    spd = 0;
    while (mode != 2'd3 && spd < 4) begin
      key_mode = 1'b0;
      step_cycles(10);
      key_mode = 1'b1;
      step_cycles(10);
      spd++;
    end
    check("pre_reset_mode", mode, 3);
    start = n_changes;
    key_mode = 1'b0;
    step_cycles(3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", led, 1);
    check("async_reset_mode", mode, 0);
    check("async_reset_tick", tick, 0);
    step_cycles(3);
    key_mode = 1'b1;
    rst_n = 1'b1;
    step_cycles(20);
    check("post_reset_no_change", n_changes - start, 0);
    check("post_reset_mode", mode, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine for the DE0-Nano LED bank. It divides CLOCK_50 down to a programmable step rate and drives one of four display modes: walking one, bounce, binary count or blink. A debounced push-button cycles through the modes. It succeeds the fixed 8-bit walking-LED divider, adding width/rate parameters, runtime speed select and mode selection.

Parameters:
LED_WIDTH, 8, number of LEDs driven; legal range 2..32.
CLK_HZ, 50000000, input clock frequency in Hz.
STEP_HZ, 1, base pattern step rate at SPEED=0; TICK_DIV = CLK_HZ/STEP_HZ, must be >= 8.
DEBOUNCE_CYCLES, 1000000, number of stable cycles required to accept a button level (20 ms at 50 MHz).

Ports:
CLOCK_50  input  1  system clock; all logic is on its rising edge.
KEY  input  1  asynchronous active-low reset.
KEY_MODE  input  1  raw mode push-button, active-low, asynchronous to CLOCK_50.
SPEED  input  2  step-rate select; step period = TICK_DIV >> SPEED cycles.
LED  output  LED_WIDTH  pattern output, registered.
MODE  output  2  current mode: 0 walk, 1 bounce, 2 count, 3 blink.
TICK  output  1  one-cycle pulse on every pattern step.

Behaviour:
- Reset (KEY=0, asynchronous assert, synchronous release through normal flops):
  - LED=1 (only the LSB lit), MODE=0, TICK=0.
  - Prescaler=0, direction=left.
  - Sync flops=1, debounced level=1, debounce counter=0.
- Prescaler:
  - Counts up each cycle. Terminal value T = (TICK_DIV >> SPEED) - 1.
  - When count >= T: count <= 0 and TICK=1 for that cycle.
  - The >= compare means a SPEED change that leaves count above the new T wraps on the next cycle. It never runs through 2^N.
- Step action (on TICK, per MODE):
  - 0 walk: rotate left by 1. MSB-only wraps to LSB-only. There is never an all-off state.
  - 1 bounce:
    - Going left: shift left; when the result is MSB-only, direction <= right.
    - Going right: shift right; when the result is LSB-only, direction <= left.
    - Endpoints are shown for exactly one step each.
  - 2 count: LED <= LED+1, modulo 2^LED_WIDTH; all-ones wraps to 0.
  - 3 blink: LED <= ~LED, alternating all-on and all-off.
- Button path:
  - KEY_MODE passes through a 2-flop synchroniser.
  - The debounce counter clears whenever the synced value equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - A press is a debounced 1->0 transition and produces one internal pulse. Release produces no action.
  - Latency from a clean input edge to the press pulse is 2 + DEBOUNCE_CYCLES cycles (+/-1). Bounce shorter than DEBOUNCE_CYCLES produces no press.
- Mode change (on press):
  - MODE <= MODE+1, wrapping 3 -> 0.
  - Prescaler cleared to 0 and direction set to left in the same cycle.
  - LED loaded with the initial pattern of the new mode: walk=1, bounce=1, count=0, blink=all-ones.
- Simultaneous press and TICK: the press wins. The step is discarded, TICK still pulses, and the prescaler is cleared.
- Held button: only one mode advance per press; the next advance needs a release to be debounced first.
- Reset mid-step or mid-debounce: all state returns to reset values immediately.
- SPEED is sampled every cycle; no synchroniser is required (quasi-static).

Test Plan:
Bench parameters for all scenarios: LED_WIDTH=8, CLK_HZ=16, STEP_HZ=1, DEBOUNCE_CYCLES=4.
1. Reset, SPEED=0, mode 0, run 9 ticks -> TICK every 16 cycles; LED 01,02,04,...,80,01; never 00.
2. Press to mode 1, run 16 ticks -> LED 01 at press, then 02,04,...,80,40,...,01,02; 80 and 01 each held one step.
3. Press to mode 2, SPEED=3 -> TICK every 2 cycles; LED 00,01,02,...; after 256 ticks LED=00. Then SPEED=3->0 while count=1 -> next TICK 15 cycles later.
4. Press to mode 3 -> LED=FF at press, then 00, FF, ...; a fourth press -> MODE=0, LED=01.
5. KEY_MODE glitches low for 3 cycles, repeatedly -> no MODE change. Held low 40 cycles -> exactly one increment, about 6 cycles after the edge.
6. Press pulse aligned with TICK in mode 0 -> LED equals the new mode's initial pattern, not the stepped value. KEY asserted mid-debounce -> LED=01, MODE=0 asynchronously.
